// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter. It shares the RAM between the CPU and one DMA/video master,
// stalls the CPU with C_HOLD, and re-reads the CPU's held address after every DMA burst.
// Optional write protection below ROM_TOP is enabled by defining MEMARB_ROM_PROTECT_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned MIN_CPU   = 1,
    parameter int unsigned ROM_TOP   = 32'h0100
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    input  logic              C_WREN,
    output logic [DATA_W-1:0] C_RDATA,
    output logic              C_HOLD,
    input  logic              D_REQ,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    input  logic              D_WREN,
    output logic              D_ACK,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    output logic              M_WREN,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic              VIOLATION
);

    localparam int unsigned CPU_CNT_W   = $clog2(MIN_CPU + 1);
    localparam int unsigned BURST_CNT_W = $clog2(MAX_BURST + 1);

`ifdef MEMARB_ROM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_CPU    = 2'd0,
        S_DMA    = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [CPU_CNT_W-1:0]   cpu_cnt, cpu_cnt_nx;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nx;
    logic                   m_wren_raw;
    logic                   prot_hit;

    // Both masters see whatever the RAM returns; each knows when its own data is valid.
    assign C_RDATA = M_RDATA;
    assign D_RDATA = M_RDATA;

    // State, counters and the DMA read-valid flag.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= S_CPU;
            cpu_cnt   <= '0;
            burst_cnt <= '0;
            D_RVALID  <= 1'b0;
        end else begin
            state     <= state_nx;
            cpu_cnt   <= cpu_cnt_nx;
            burst_cnt <= burst_cnt_nx;
            D_RVALID  <= (state == S_DMA) && !D_WREN;
        end
    end

    // Next-state and RAM mux decode.
    always_comb begin
        state_nx     = state;
        cpu_cnt_nx   = cpu_cnt;
        burst_cnt_nx = burst_cnt;
        M_ADDR       = C_ADDR;
        M_WDATA      = C_WDATA;
        m_wren_raw   = 1'b0;
        C_HOLD       = 1'b0;
        D_ACK        = 1'b0;
        case (state)
            S_CPU: begin
                m_wren_raw = C_WREN;
                if (32'(cpu_cnt) < MIN_CPU) begin
                    cpu_cnt_nx = cpu_cnt + CPU_CNT_W'(1);
                end
                if (D_REQ && (32'(cpu_cnt) + 32'd1 >= MIN_CPU)) begin
                    state_nx = S_DMA;
                end
            end
            S_DMA: begin
                M_ADDR       = D_ADDR;
                M_WDATA      = D_WDATA;
                m_wren_raw   = D_WREN;
                D_ACK        = 1'b1;
                C_HOLD       = 1'b1;
                burst_cnt_nx = burst_cnt + BURST_CNT_W'(1);
                if (!(D_REQ && (32'(burst_cnt) < MAX_BURST - 32'd1))) begin
                    state_nx = S_REFILL;
                end
            end
            S_REFILL: begin
                // RAM re-reads the CPU's held address so its first free cycle sees fresh data.
                C_HOLD       = 1'b1;
                burst_cnt_nx = '0;
                cpu_cnt_nx   = '0;
                state_nx     = S_CPU;
            end
            default: begin
                state_nx = S_CPU;
            end
        endcase
    end

    assign prot_hit = PROT_EN && m_wren_raw && (32'(M_ADDR) < ROM_TOP);
    assign M_WREN   = m_wren_raw && !prot_hit;

`ifdef MEMARB_ROM_PROTECT_EN
    // One-cycle pulse for each suppressed write into the protected region.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            VIOLATION <= 1'b0;
        end else begin
            VIOLATION <= prot_hit;
        end
    end
`else
    assign VIOLATION = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU access, single DMA read with refill, burst limits,
// held CPU write, reset mid-burst and the protected-region write.
module tb_mem_arbiter;

    logic        CLOCK;
    logic        RESET;
    logic [15:0] C_ADDR;
    logic [7:0]  C_WDATA;
    logic        C_WREN;
    logic [7:0]  C_RDATA;
    logic        C_HOLD;
    logic        D_REQ;
    logic [15:0] D_ADDR;
    logic [7:0]  D_WDATA;
    logic        D_WREN;
    logic        D_ACK;
    logic        D_RVALID;
    logic [7:0]  D_RDATA;
    logic [15:0] M_ADDR;
    logic [7:0]  M_WDATA;
    logic        M_WREN;
    logic [7:0]  M_RDATA;
    logic        VIOLATION;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

`ifdef MEMARB_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    mem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .MAX_BURST(4),
        .MIN_CPU  (1),
        .ROM_TOP  (32'h0100)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .C_ADDR   (C_ADDR),
        .C_WDATA  (C_WDATA),
        .C_WREN   (C_WREN),
        .C_RDATA  (C_RDATA),
        .C_HOLD   (C_HOLD),
        .D_REQ    (D_REQ),
        .D_ADDR   (D_ADDR),
        .D_WDATA  (D_WDATA),
        .D_WREN   (D_WREN),
        .D_ACK    (D_ACK),
        .D_RVALID (D_RVALID),
        .D_RDATA  (D_RDATA),
        .M_ADDR   (M_ADDR),
        .M_WDATA  (M_WDATA),
        .M_WREN   (M_WREN),
        .M_RDATA  (M_RDATA),
        .VIOLATION(VIOLATION)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Synchronous RAM with one-cycle read latency; preloaded while reset is held.
    always @(posedge CLOCK) begin
        if (RESET) begin
            mem[16'h8000] <= 8'hC3;
            mem[16'h0010] <= 8'h00;
            mem[16'h0200] <= 8'h00;
        end else if (M_WREN) begin
            mem[M_ADDR] <= M_WDATA;
        end
        M_RDATA <= mem[M_ADDR];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [11:0] exp_ack;
    logic [11:0] exp_hold;
    int          run;
    int          run_max;
    logic        released;

    initial begin
        RESET   = 1'b1;
        C_ADDR  = 16'h0000;
        C_WDATA = 8'h00;
        C_WREN  = 1'b0;
        D_REQ   = 1'b0;
        D_ADDR  = 16'h0000;
        D_WDATA = 8'h00;
        D_WREN  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("reset_hold", 32'(C_HOLD), 32'd0);
        chk("reset_ack", 32'(D_ACK), 32'd0);
        chk("reset_rvalid", 32'(D_RVALID), 32'd0);
        chk("reset_violation", 32'(VIOLATION), 32'd0);
        RESET = 1'b0;

        // CPU write 0x5A to 0x1234, then read it back
        C_ADDR  = 16'h1234;
        C_WDATA = 8'h5A;
        C_WREN  = 1'b1;
        settle();
        chk("cpu_wr_addr", 32'(M_ADDR), 32'h1234);
        chk("cpu_wr_en", 32'(M_WREN), 32'd1);
        chk("cpu_wr_data", 32'(M_WDATA), 32'h5A);
        chk("cpu_wr_hold", 32'(C_HOLD), 32'd0);
        tick();
        C_WREN = 1'b0;
        tick();
        settle();
        chk("cpu_rd_data", 32'(C_RDATA), 32'h5A);
        for (int i = 0; i < 100; i++) begin
            tick();
            settle();
            chk("idle_hold", 32'(C_HOLD), 32'd0);
        end

        // Single DMA read of 0x8000 with refill
        D_ADDR = 16'h8000;
        D_WREN = 1'b0;
        D_REQ  = 1'b1;
        settle();
        chk("req_no_ack_yet", 32'(D_ACK), 32'd0);
        tick();
        settle();
        chk("dma_ack", 32'(D_ACK), 32'd1);
        chk("dma_addr", 32'(M_ADDR), 32'h8000);
        chk("dma_hold", 32'(C_HOLD), 32'd1);
        chk("dma_wren", 32'(M_WREN), 32'd0);
        D_REQ = 1'b0;
        tick();
        settle();
        chk("dma_rvalid", 32'(D_RVALID), 32'd1);
        chk("dma_rdata", 32'(D_RDATA), 32'hC3);
        chk("refill_hold", 32'(C_HOLD), 32'd1);
        chk("refill_addr", 32'(M_ADDR), 32'h1234);
        chk("refill_ack", 32'(D_ACK), 32'd0);
        tick();
        settle();
        chk("release_hold", 32'(C_HOLD), 32'd0);
        chk("rvalid_clear", 32'(D_RVALID), 32'd0);
        chk("refill_rdata", 32'(C_RDATA), 32'h5A);

        // D_REQ held 12 cycles: 4 acks, refill, 1 CPU, 4 acks, refill
        exp_ack  = 12'b0111_1001_1110;
        exp_hold = 12'b1111_1011_1110;
        run      = 0;
        run_max  = 0;
        D_REQ    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            settle();
            chk("burst_ack", 32'(D_ACK), 32'(exp_ack[i]));
            chk("burst_hold", 32'(C_HOLD), 32'(exp_hold[i]));
            if (D_ACK) run++;
            else run = 0;
            if (run > run_max) run_max = run;
            tick();
        end
        D_REQ = 1'b0;
        chk("burst_max_run", 32'(run_max), 32'd4);

        // CPU write to 0x0200 presented while the DMA owns the bus
        D_ADDR = 16'h9000;
        D_WREN = 1'b0;
        D_REQ  = 1'b1;
        tick();
        settle();
        chk("wrhold_ack", 32'(D_ACK), 32'd1);
        C_ADDR  = 16'h0200;
        C_WDATA = 8'h77;
        C_WREN  = 1'b1;
        D_REQ   = 1'b0;
        released = 1'b0;
        for (int i = 0; i < 8 && !released; i++) begin
            settle();
            if (C_HOLD) begin
                chk("held_no_write", 32'(M_WREN), 32'd0);
                tick();
            end else begin
                chk("adv_wr_addr", 32'(M_ADDR), 32'h0200);
                chk("adv_wr_en", 32'(M_WREN), 32'd1);
                released = 1'b1;
            end
        end
        chk("hold_released", 32'(released), 32'd1);
        tick();
        C_WREN = 1'b0;
        C_ADDR = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("no_rewrite", 32'(M_WREN), 32'd0);
            tick();
        end
        chk("mem_0200", 32'(mem[16'h0200]), 32'h77);

        // Reset during the second DMA cycle
        D_ADDR = 16'hA000;
        D_REQ  = 1'b1;
        tick();
        settle();
        chk("rst_ack1", 32'(D_ACK), 32'd1);
        tick();
        settle();
        chk("rst_ack2", 32'(D_ACK), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        D_REQ = 1'b0;
        settle();
        chk("rst_hold", 32'(C_HOLD), 32'd0);
        chk("rst_ack", 32'(D_ACK), 32'd0);
        chk("rst_rvalid", 32'(D_RVALID), 32'd0);
        chk("rst_cpu_addr", 32'(M_ADDR), 32'h1234);
        tick();
        settle();
        chk("rst_no_reack", 32'(D_ACK), 32'd0);

        // DMA write into the low (protectable) region
        D_ADDR  = 16'h0010;
        D_WDATA = 8'h99;
        D_WREN  = 1'b1;
        D_REQ   = 1'b1;
        tick();
        settle();
        chk("rom_ack", 32'(D_ACK), 32'd1);
        chk("rom_addr", 32'(M_ADDR), 32'h0010);
        chk("rom_wren", 32'(M_WREN), PROT ? 32'd0 : 32'd1);
        D_REQ = 1'b0;
        tick();
        settle();
        chk("rom_violation", 32'(VIOLATION), PROT ? 32'd1 : 32'd0);
        chk("rom_rvalid", 32'(D_RVALID), 32'd0);
        tick();
        settle();
        chk("rom_violation_clear", 32'(VIOLATION), 32'd0);
        chk("rom_mem", 32'(mem[16'h0010]), PROT ? 32'h00 : 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous byte RAM (1-cycle read latency) between the 8-bit CPU and one secondary master (DMA/video fetch).
- Sits between the CPU bus (address, write data, write enable, read data) and the RAM. Steals cycles for the secondary master and stalls the CPU with a clock-enable style hold.
- Inserts a refill cycle so the CPU always sees read data for its own held address.

Parameters:
- ADDR_W, 16: address width.
- DATA_W, 8: data width.
- MAX_BURST, 4: maximum consecutive DMA grants before the bus returns to the CPU (at least 1).
- MIN_CPU, 1: minimum consecutive CPU cycles between DMA bursts (at least 1).
- ROM_TOP, 16'h0100: write-protect limit; used only with the optional feature.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- C_ADDR  in  ADDR_W  CPU address.
- C_WDATA  in  DATA_W  CPU write data.
- C_WREN  in  1  CPU write enable.
- C_RDATA  out  DATA_W  CPU read data; wired to M_RDATA.
- C_HOLD  out  1  CPU must not advance on this edge.
- D_REQ  in  1  DMA request.
- D_ADDR  in  ADDR_W  DMA address.
- D_WDATA  in  DATA_W  DMA write data.
- D_WREN  in  1  DMA write enable.
- D_ACK  out  1  DMA access issued this cycle.
- D_RVALID  out  1  D_RDATA valid.
- D_RDATA  out  DATA_W  DMA read data; wired to M_RDATA.
- M_ADDR  out  ADDR_W  RAM address.
- M_WDATA  out  DATA_W  RAM write data.
- M_WREN  out  1  RAM write enable.
- M_RDATA  in  DATA_W  RAM read data, valid one cycle after the address.
- VIOLATION  out  1  protected-write pulse; tied to 0 without the optional feature.

Behaviour:
- Clocking: one clock (CLOCK). RESET is synchronous and active-high.
- States: S_CPU, S_DMA, S_REFILL. The state register is registered; all outputs are decoded from the state and the current inputs.
- S_CPU:
  - M_ADDR/M_WDATA/M_WREN = C_ADDR/C_WDATA/C_WREN.
  - C_HOLD=0, D_ACK=0.
  - cpu_cnt saturates at MIN_CPU.
  - Go to S_DMA when D_REQ=1 and cpu_cnt+1 >= MIN_CPU; otherwise stay.
- S_DMA:
  - M_* = D_*; D_ACK=1; C_HOLD=1.
  - burst_cnt increments.
  - Stay while D_REQ=1 and burst_cnt < MAX_BURST-1; otherwise go to S_REFILL.
  - D_REQ is sampled on the ACK edge; a master keeping REQ high requests the next access.
- S_REFILL:
  - M_ADDR=C_ADDR, M_WREN=0, C_HOLD=1, D_ACK=0. Go to S_CPU.
  - Clear burst_cnt and cpu_cnt.
  - Purpose: the RAM re-reads the CPU's held address, so the CPU's first advancing cycle sees correct C_RDATA.
- CPU writes:
  - A CPU write is issued only in S_CPU cycles, never while C_HOLD=1.
  - A held write is performed exactly once, on the CPU's advancing edge.
- D_RVALID: registered. Set the cycle after an ACK with D_WREN=0; 0 otherwise.
- DMA handshake: D_ADDR/D_WDATA/D_WREN must be stable while D_REQ=1 and ACK is not yet given. Deasserting REQ before ACK withdraws the request.
- Simultaneous CPU and DMA demand: the DMA wins once MIN_CPU is met. The CPU is starved for at most MAX_BURST+1 cycles.
- Reset values:
  - State S_CPU; counters 0.
  - D_RVALID=0 and VIOLATION=0.
  - C_HOLD=0 and D_ACK=0, decoded from S_CPU.
- Reset mid-burst: the pending DMA access is dropped and not acked again. No refill is needed because the CPU is also reset.

Optional Feature:
- Macro: MEMARB_ROM_PROTECT_EN.
- Defined:
  - Any write (CPU or DMA) with address < ROM_TOP forces M_WREN=0.
  - VIOLATION pulses for one cycle, registered.
  - D_ACK is still given to the DMA.
  - The CPU is not stalled.
- Undefined: all writes pass through and VIOLATION is constant 0.

Test Plan:
- No DMA, CPU writes 0x5A to 0x1234 -> M_ADDR=0x1234, M_WREN=1 same cycle; C_HOLD stays 0 for 100 cycles.
- D_REQ pulse (held until ACK), DMA read of 0x8000, REQ seen at edge n:
  - Cycle n+1: D_ACK=1, M_ADDR=0x8000, C_HOLD=1.
  - Cycle n+2: D_RVALID=1 with D_RDATA=mem[0x8000]; S_REFILL with C_HOLD=1, M_ADDR=C_ADDR.
  - Cycle n+3: C_HOLD=0.
- MAX_BURST=4, MIN_CPU=1, D_REQ held 12 cycles -> ACK pattern: 4 acks, refill, 1 CPU cycle, 4 acks, refill, and so on; never 5 consecutive acks.
- C_WREN=1 to 0x0200 while entering S_DMA -> no RAM write during DMA or refill cycles; exactly one M_WREN=1 cycle at 0x0200 after return to S_CPU.
- RESET asserted during the second DMA cycle -> next cycle: S_CPU, C_HOLD=0, D_ACK=0, D_RVALID=0.
- With MEMARB_ROM_PROTECT_EN, DMA write to 0x0010 -> M_WREN=0, D_ACK=1, VIOLATION=1 for one cycle. Without the macro -> M_WREN=1 and the RAM is updated.
